score_display: RTL and testbench

//  Reads the 8-bit game score and shows it in decimal on a multiplexed 4-anode 7-segment display.

---
 rtl/score_display_pkg.sv | 35 +++
 rtl/score_display_if.sv | 17 +
 rtl/score_display_bin2bcd_seq.sv | 85 ++++++++
 rtl/score_display.sv | 108 ++++++++++
 tb/tb_score_display.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: conversion states,
// segment patterns and the double-dabble nibble adjust step.
package score_disp_pkg;

    localparam int BCD_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_t;

    typedef logic [1:0] digit_sel_t;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] BLANK_SEG = 7'h00;

    function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// Bus between the score register side and the display block: the score
// coming in, and segment/anode pins plus conversion status going out.
interface score_display_if
    import score_disp_pkg::*;
#(
    parameter int SCORE_W = 8
);
    logic [SCORE_W-1:0] score;
    logic [6:0]         seg;
    logic [3:0]         an;
    logic [BCD_W-1:0]   bcd;
    logic               busy;

    modport master (output score, input seg, an, bcd, busy);
    modport slave  (input score, output seg, an, bcd, busy);

endinterface

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per clock,
// result published only once the whole conversion has finished.
module bin2bcd_seq
    import score_disp_pkg::*;
#(
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [SCORE_W-1:0] i_score,
    output logic               o_busy,
    output logic               o_done,
    output logic [BCD_W-1:0]   o_bcd,
    output logic [SCORE_W-1:0] o_cap
);
    localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCORE_W - 1);

    conv_state_t        r_state;
    conv_state_t        w_next;
    logic [SCORE_W-1:0] r_cap;
    logic [SCORE_W-1:0] r_sh;
    logic [BCD_W-1:0]   r_acc;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   w_adj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = LOAD;
            LOAD:    w_next = SHIFT;
            SHIFT:   if (r_cnt == LAST_CNT) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_adj = add3_adjust(r_acc);

    // The score is captured in IDLE so later input changes cannot disturb a running conversion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap <= '0;
            r_sh  <= '0;
            r_acc <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) r_cap <= i_score;
                end
                LOAD: begin
                    r_sh  <= r_cap;
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                SHIFT: begin
                    {r_acc, r_sh} <= {w_adj, r_sh} << 1;
                    r_cnt         <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_bcd <= r_acc;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == DONE);
    assign o_bcd  = r_bcd;
    assign o_cap  = r_cap;

endmodule

// File: rtl/score_display.sv
// Shows the binary game score in decimal on a multiplexed 4-anode 7-segment
// display, converting only when the score differs from the last one shown.
module score_display
    import score_disp_pkg::*;
#(
    parameter int SCORE_W        = 8,
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic            clk,
    input logic            rst,
    score_display_if.slave bus
);
    localparam int               RC_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_OFF = SEG_ACTIVE_LOW ? ~BLANK_SEG : BLANK_SEG;
    localparam logic [3:0]       AN_OFF  = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

    logic               r_valid;
    logic [SCORE_W-1:0] r_last;
    logic [RC_W-1:0]    r_rcnt;
    digit_sel_t         r_digit_sel;
    logic [6:0]         r_seg;
    logic [3:0]         r_an;

    logic               w_start;
    logic               w_busy;
    logic               w_done;
    logic [BCD_W-1:0]   w_bcd;
    logic [SCORE_W-1:0] w_cap;
    logic [3:0]         w_digit;
    logic               w_blank;
    logic [6:0]         w_seg_on;
    logic [3:0]         w_an_on;

    assign w_start = !r_valid || (bus.score != r_last);

    bin2bcd_seq #(
        .SCORE_W (SCORE_W)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_score (bus.score),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd),
        .o_cap   (w_cap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= '0;
        end else if (w_done) begin
            r_valid <= 1'b1;
            r_last  <= w_cap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rcnt      <= '0;
            r_digit_sel <= 2'd0;
        end else if (r_rcnt == RC_LAST) begin
            r_rcnt      <= '0;
            r_digit_sel <= (r_digit_sel == 2'd2) ? 2'd0 : r_digit_sel + 2'd1;
        end else begin
            r_rcnt <= r_rcnt + 1'b1;
        end
    end

    // Leading-zero blanking: a blank slot lights nothing at all, anode included
    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        case (r_digit_sel)
            2'd0: w_digit = w_bcd[3:0];
            2'd1: begin
                w_digit = w_bcd[7:4];
                w_blank = (w_bcd[11:8] == 4'd0) && (w_bcd[7:4] == 4'd0);
            end
            2'd2: begin
                w_digit = w_bcd[11:8];
                w_blank = (w_bcd[11:8] == 4'd0);
            end
            default: w_blank = 1'b1;
        endcase
        w_seg_on = w_blank ? BLANK_SEG : SEG_LUT[w_digit];
        w_an_on  = w_blank ? 4'b0000 : (4'b0001 << r_digit_sel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= SEG_ACTIVE_LOW ? ~w_seg_on : w_seg_on;
            r_an  <= SEG_ACTIVE_LOW ? ~w_an_on : w_an_on;
        end
    end

    assign bus.seg  = r_seg;
    assign bus.an   = r_an;
    assign bus.bcd  = w_bcd;
    assign bus.busy = w_busy;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: directed scenarios plus randomized scores checked
// against a decimal-arithmetic reference model of conversion and scanning.
module tb_score_display;
    localparam int SCORE_W     = 8;
    localparam int REFRESH_DIV = 4;
    localparam int CONV_CYCLES = SCORE_W + 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    int         mLeft;
    int         mCap;
    int         mLast;
    int         mVal;
    int         mRcnt;
    int         mSel;
    bit         mValid;
    logic [6:0] mSeg;
    logic [3:0] mAn;

    score_display_if #(.SCORE_W(SCORE_W)) bus ();

    score_display #(
        .SCORE_W        (SCORE_W),
        .REFRESH_DIV    (REFRESH_DIV),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] digitGlyph(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic bit slotBlank(input int sel, input int v);
        if (sel == 1) return (v < 10);
        if (sel == 2) return (v < 100);
        return 1'b0;
    endfunction

    function automatic int slotDigit(input int sel, input int v);
        if (sel == 1) return (v / 10) % 10;
        if (sel == 2) return v / 100;
        return v % 10;
    endfunction

    function automatic logic [6:0] expSeg(input int sel, input int v);
        if (slotBlank(sel, v)) return 7'h7F;
        return ~digitGlyph(slotDigit(sel, v));
    endfunction

    function automatic logic [3:0] expAn(input int sel, input int v);
        if (slotBlank(sel, v)) return 4'hF;
        return ~(4'b0001 << sel);
    endfunction

    function automatic logic [11:0] toBcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Reference model: a conversion is a fixed-length busy window, the display a slot rotation
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mLeft  <= 0;
            mCap   <= 0;
            mLast  <= 0;
            mVal   <= 0;
            mValid <= 1'b0;
            mRcnt  <= 0;
            mSel   <= 0;
            mSeg   <= 7'h7F;
            mAn    <= 4'hF;
        end else begin
            if (mLeft == 0) begin
                if (!mValid || int'(bus.score) != mLast) begin
                    mCap  <= int'(bus.score);
                    mLeft <= CONV_CYCLES;
                end
            end else begin
                if (mLeft == 1) begin
                    mVal   <= mCap;
                    mLast  <= mCap;
                    mValid <= 1'b1;
                end
                mLeft <= mLeft - 1;
            end
            mSeg <= expSeg(mSel, mVal);
            mAn  <= expAn(mSel, mVal);
            if (mRcnt == REFRESH_DIV - 1) begin
                mRcnt <= 0;
                mSel  <= (mSel + 1) % 3;
            end else begin
                mRcnt <= mRcnt + 1;
            end
        end
    end

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy === 1'b1 && n < budget);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_idle busy=%b required 0 within %0d cycles", bus.busy, budget);
        end
    endtask

    task automatic test_reset();
        int busyCycles;
        bit seenOnes;
        bus.score = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.bcd !== 12'h000) begin errors++; $display("[TB] FAIL reset_bcd got=%h exp=000", bus.bcd); end
        checks++;
        if (bus.seg !== 7'h7F) begin errors++; $display("[TB] FAIL reset_seg got=%h exp=7f", bus.seg); end
        checks++;
        if (bus.an !== 4'hF) begin errors++; $display("[TB] FAIL reset_an got=%h exp=f", bus.an); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        busyCycles = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busyCycles++;
        end
        checks++;
        if (busyCycles != CONV_CYCLES) begin
            errors++;
            $display("[TB] FAIL first_conv_busy_len got=%0d exp=%0d", busyCycles, CONV_CYCLES);
        end
        checks++;
        if (bus.bcd !== 12'h000) begin errors++; $display("[TB] FAIL first_conv_bcd got=%h exp=000", bus.bcd); end
        seenOnes = 1'b0;
        repeat (3 * REFRESH_DIV) begin
            @(negedge clk);
            checks++;
            if (bus.an === 4'b1110) begin
                seenOnes = 1'b1;
                if (bus.seg !== 7'h40) begin errors++; $display("[TB] FAIL zero_ones_seg got=%h exp=40", bus.seg); end
            end else if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
                errors++;
                $display("[TB] FAIL zero_blank_slot an=%b seg=%h exp an=1111 seg=7f", bus.an, bus.seg);
            end
        end
        checks++;
        if (!seenOnes) begin errors++; $display("[TB] FAIL zero_ones_slot_seen got=0 exp=1"); end
    endtask

    task automatic test_convert_125();
        bit seen0;
        bit seen1;
        bit seen2;
        bus.score = 8'd125;
        repeat (CONV_CYCLES) @(negedge clk);
        checks++;
        if (bus.bcd !== 12'h000) begin errors++; $display("[TB] FAIL latency_early_bcd got=%h exp=000", bus.bcd); end
        @(negedge clk);
        checks++;
        if (bus.bcd !== 12'h125) begin errors++; $display("[TB] FAIL latency_bcd got=%h exp=125", bus.bcd); end
        @(negedge clk);
        {seen0, seen1, seen2} = 3'b000;
        repeat (3 * REFRESH_DIV) begin
            @(negedge clk);
            checks++;
            case (bus.an)
                4'b1110: begin
                    seen0 = 1'b1;
                    if (bus.seg !== 7'h12) begin errors++; $display("[TB] FAIL scan125_ones got=%h exp=12", bus.seg); end
                end
                4'b1101: begin
                    seen1 = 1'b1;
                    if (bus.seg !== 7'h24) begin errors++; $display("[TB] FAIL scan125_tens got=%h exp=24", bus.seg); end
                end
                4'b1011: begin
                    seen2 = 1'b1;
                    if (bus.seg !== 7'h79) begin errors++; $display("[TB] FAIL scan125_hund got=%h exp=79", bus.seg); end
                end
                default: begin
                    errors++;
                    $display("[TB] FAIL scan125_anode got=%b exp=one of 1110/1101/1011", bus.an);
                end
            endcase
        end
        checks++;
        if ({seen0, seen1, seen2} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL scan125_slots_seen got=%b exp=111", {seen0, seen1, seen2});
        end
    endtask

    task automatic test_wrap();
        logic [7:0] s;
        s = 8'd255;
        bus.score = s;
        waitIdle(30);
        checks++;
        if (bus.bcd !== 12'h255) begin errors++; $display("[TB] FAIL wrap_max_bcd got=%h exp=255", bus.bcd); end
        s = s + 8'd5;
        bus.score = s;
        waitIdle(30);
        checks++;
        if (bus.bcd !== 12'h004) begin errors++; $display("[TB] FAIL wrap_bcd got=%h exp=004", bus.bcd); end
        @(negedge clk);
        repeat (3 * REFRESH_DIV) begin
            @(negedge clk);
            checks++;
            if (bus.an === 4'b1110) begin
                if (bus.seg !== 7'h19) begin errors++; $display("[TB] FAIL wrap_ones_seg got=%h exp=19", bus.seg); end
            end else if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
                errors++;
                $display("[TB] FAIL wrap_blank_slot an=%b seg=%h exp an=1111 seg=7f", bus.an, bus.seg);
            end
        end
    endtask

    task automatic test_mid_change();
        bus.score = 8'd10;
        repeat (4) @(negedge clk);
        bus.score = 8'd15;
        waitIdle(30);
        checks++;
        if (bus.bcd !== 12'h010) begin errors++; $display("[TB] FAIL midchg_first_bcd got=%h exp=010", bus.bcd); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL midchg_restart_busy got=%b exp=1", bus.busy); end
        waitIdle(30);
        checks++;
        if (bus.bcd !== 12'h015) begin errors++; $display("[TB] FAIL midchg_second_bcd got=%h exp=015", bus.bcd); end
    endtask

    task automatic test_hold();
        repeat (50) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_busy got=%b exp=0", bus.busy); end
            checks++;
            if (bus.bcd !== 12'h015) begin errors++; $display("[TB] FAIL hold_bcd got=%h exp=015", bus.bcd); end
        end
    endtask

    task automatic test_reset_mid();
        int s;
        s = $urandom_range(16, 254);
        bus.score = 8'(s);
        @(negedge clk);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.bcd !== 12'h000) begin errors++; $display("[TB] FAIL rstmid_bcd got=%h exp=000", bus.bcd); end
        checks++;
        if (bus.seg !== 7'h7F || bus.an !== 4'hF) begin
            errors++;
            $display("[TB] FAIL rstmid_display seg=%h an=%h exp seg=7f an=f", bus.seg, bus.an);
        end
        @(negedge clk);
        rst = 1'b0;
        waitIdle(30);
        checks++;
        if (bus.bcd !== toBcd(s)) begin
            errors++;
            $display("[TB] FAIL rstmid_reconv_bcd got=%h exp=%h", bus.bcd, toBcd(s));
        end
    endtask

    task automatic test_random();
        int bounds [6];
        int hold;
        bounds = '{0, 9, 10, 99, 100, 255};
        for (int i = 0; i < 36; i++) begin
            if (i < 6) bus.score = 8'(bounds[i]);
            else       bus.score = 8'($urandom_range(0, 255));
            hold = (i < 6) ? CONV_CYCLES + 3 * REFRESH_DIV + 2 : $urandom_range(1, 14);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                checks++;
                if (bus.busy !== (mLeft != 0)) begin
                    errors++;
                    $display("[TB] FAIL rand_busy got=%b exp=%b score=%0d", bus.busy, (mLeft != 0), bus.score);
                end
                checks++;
                if (bus.bcd !== toBcd(mVal)) begin
                    errors++;
                    $display("[TB] FAIL rand_bcd got=%h exp=%h", bus.bcd, toBcd(mVal));
                end
                checks++;
                if (bus.seg !== mSeg || bus.an !== mAn) begin
                    errors++;
                    $display("[TB] FAIL rand_display seg=%h an=%b exp seg=%h an=%b", bus.seg, bus.an, mSeg, mAn);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        bus.score = '0;
        test_reset();
        test_convert_125();
        test_wrap();
        test_mid_change();
        test_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
